mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Multiply is shift-add over operand magnitudes; divide is restoring
// shift-subtract. Each operation takes 32 cycles in RUN and then writes HI/LO
// on the FIN entry edge, applying the sign fix for the signed variants.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDCon,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // MDCon[1] selects divide, MDCon[0] selects signed.
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;   // mul: {partial, multiplier}; div: {rem, quot}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes of the latched operation.
  logic        is_div, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  // Magnitudes of the operands presented with Start, used to seed acc.
  logic        in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  // One iteration of each algorithm and the sign-fixed final result.
  logic [32:0] sum33;
  logic [32:0] rem_sh;
  logic [31:0] quot_sh;
  logic [63:0] mul_next, div_next, step;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_FIN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Datapath: magnitudes, one multiply/divide step, and final sign fix.
  always_comb begin
    is_div   = op_q[1];
    neg_a    = op_q[0] & a_q[31];
    neg_b    = op_q[0] & b_q[31];
    mag_a    = neg_a ? -a_q : a_q;
    mag_b    = neg_b ? -b_q : b_q;

    in_neg_a = MDCon[0] & A[31];
    in_neg_b = MDCon[0] & B[31];
    in_mag_a = in_neg_a ? -A : A;
    in_mag_b = in_neg_b ? -B : B;

    // Shift-add: add multiplicand into the upper half when the LSB is set,
    // then shift the whole 65-bit {carry, acc} right by one.
    sum33    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a} : 33'd0);
    mul_next = {sum33, acc_q[31:1]};

    // Restoring divide: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the
    // divisor, so the 32-bit difference is exact.
    rem_sh   = {acc_q[63:32], acc_q[31]};
    quot_sh  = {acc_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, mag_b}) begin
      div_next = {rem_sh[31:0] - mag_b, quot_sh | 32'd1};
    end else begin
      div_next = {rem_sh[31:0], quot_sh};
    end

    step     = is_div ? div_next : mul_next;

    prod_fix = (neg_a ^ neg_b) ? -step : step;
    quot_fix = (neg_a ^ neg_b) ? -step[31:0] : step[31:0];
    rem_fix  = neg_a ? -step[63:32] : step[63:32];
  end

  // Next-state, operand capture, iteration and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
          if (!is_div) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: begin  // S_IDLE, S_FIN
        state_d = S_IDLE;
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = 5'd0;
          op_d    = MDCon;
          a_d     = A;
          b_d     = B;
          acc_d   = MDCon[1] ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
        end else begin
          if (HIWrite) hi_d = A;
          if (LOWrite) lo_d = A;
        end
      end
    endcase
  end

  // Control state and architecturally visible HI/LO, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand and working registers.
  // NOTE: no reset here on purpose; these are always loaded on Start before
  // being read, so resetting them only adds fanout on the reset net.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MDCon = 2'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        HIWrite = 1'b0;
  logic        LOWrite = 1'b0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDCon  (MDCon),
    .A      (A),
    .B      (B),
    .HIWrite(HIWrite),
    .LOWrite(LOWrite),
    .Busy   (Busy),
    .Done   (Done),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {HI, LO} from plain arithmetic on the operation definition.
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: return 64'(sa * sb);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Present an operation at the next edge; scramble inputs afterwards so
  // the result proves the operands were latched.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDCon = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    MDCon = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
    check("accept_busy", 64'(Busy), 64'd1);
    check("accept_done", 64'(Done), 64'd0);
  endtask

  // Wait (bounded) for Done and check latency, busy length, HI/LO hold and
  // the result. Optionally inject ignored Start/HIWrite pulses mid-run, and
  // optionally chain a new Start in FIN.
  task automatic finish_op(input string tag, input logic [63:0] res,
                           input bit inject, input bit chain,
                           input logic [1:0] nop, input logic [31:0] na,
                           input logic [31:0] nb);
    int cyc = 0;
    int busy_cnt = 0;
    bit hold = 1'b1;
    while (!Done && cyc < 40) begin
      if (Busy) busy_cnt++;
      if (HI !== exp_hi || LO !== exp_lo) hold = 1'b0;
      if (inject) begin
        Start   = (cyc == 5 || cyc == 20);
        HIWrite = (cyc == 10);
        if (cyc == 5 || cyc == 20) begin
          MDCon = 2'($urandom);
          A     = $urandom;
          B     = $urandom;
        end
        if (cyc == 10) A = 32'h1234;
      end
      tick();
      cyc++;
    end
    Start   = 1'b0;
    HIWrite = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_hold_in_run"}, 64'(hold), 64'd1);
    check({tag, "_done"}, 64'(Done), 64'd1);
    check({tag, "_busy_at_fin"}, 64'(Busy), 64'd0);
    check({tag, "_hi"}, 64'(HI), 64'(res[63:32]));
    check({tag, "_lo"}, 64'(LO), 64'(res[31:0]));
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    if (chain) begin
      start_op(nop, na, nb);
    end else begin
      tick();
      check({tag, "_done_fall"}, 64'(Done), 64'd0);
      check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
      check({tag, "_hi_hold"}, 64'(HI), 64'(exp_hi));
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    int          done_seen;

    // Reset and first Start at the first edge after reset deasserts.
    tick();
    tick();
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    reset = 1'b0;
    start_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 64'hFFFF_FFFE_0000_0001, 0, 0, 2'd0, 0, 0);

    // Signed multiply and signed/unsigned divide corners.
    start_op(2'd1, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 2'd0, 0, 0);
    start_op(2'd3, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 2'd0, 0, 0);
    start_op(2'd2, 32'd100, 32'd0);
    finish_op("divu_zero", {32'd100, 32'hFFFF_FFFF}, 0, 0, 2'd0, 0, 0);
    start_op(2'd3, 32'hFFFF_FF00, 32'd0);
    finish_op("div_zero", {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0, 0, 2'd0, 0, 0);
    start_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_min", {32'd0, 32'h8000_0000}, 0, 0, 2'd0, 0, 0);

    // Start and HIWrite pulses during RUN are ignored.
    start_op(2'd0, 32'h0001_0003, 32'h0000_1005);
    finish_op("ignore_mid", ref_result(2'd0, 32'h0001_0003, 32'h0000_1005), 1, 0, 2'd0, 0, 0);

    // MTHI / MTLO / both, when idle.
    A = 32'hCAFE_0001; HIWrite = 1'b1; tick(); HIWrite = 1'b0;
    exp_hi = 32'hCAFE_0001;
    check("mthi_hi", 64'(HI), 64'(exp_hi));
    check("mthi_lo", 64'(LO), 64'(exp_lo));
    A = 32'hBEEF_0002; LOWrite = 1'b1; tick(); LOWrite = 1'b0;
    exp_lo = 32'hBEEF_0002;
    check("mtlo_lo", 64'(LO), 64'(exp_lo));
    check("mtlo_hi", 64'(HI), 64'(exp_hi));
    A = 32'h5A5A_A5A5; HIWrite = 1'b1; LOWrite = 1'b1; tick();
    HIWrite = 1'b0; LOWrite = 1'b0;
    exp_hi = 32'h5A5A_A5A5;
    exp_lo = 32'h5A5A_A5A5;
    check("mthilo_hi", 64'(HI), 64'(exp_hi));
    check("mthilo_lo", 64'(LO), 64'(exp_lo));

    // Start wins over a simultaneous HIWrite.
    Start = 1'b1; HIWrite = 1'b1; MDCon = 2'd0; A = 32'd5; B = 32'd6;
    tick();
    Start = 1'b0; HIWrite = 1'b0;
    check("start_wins_busy", 64'(Busy), 64'd1);
    check("start_wins_hi", 64'(HI), 64'(exp_hi));
    finish_op("start_wins", 64'd30, 0, 0, 2'd0, 0, 0);

    // Reset mid-RUN aborts with no result and no Done.
    start_op(2'd1, 32'h1234_5678, 32'h8765_4321);
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_seen++;
      tick();
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Back-to-back: Start accepted in FIN, no IDLE cycle in between.
    start_op(2'd0, 32'd3, 32'd5);
    finish_op("b2b_first", 64'd15, 0, 1, 2'd2, 32'd100, 32'd7);
    finish_op("b2b_second", {32'd2, 32'd14}, 0, 0, 2'd0, 0, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      start_op(op, ra, rb);
      finish_op("rand", ref_result(op, ra, rb), 0, 0, 2'd0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
